// File: rtl/dict_codec_engine_pkg.sv
// dict_codec_pkg: shared types for the dictionary codec engine.
//   cmd_e   : request opcodes (NOP, COMP, DECOMP, CLEAR)
//   rsp_e   : response status (NONE, COMP, DECOMP, ERR)
//   state_e : engine FSM states (IDLE, SEARCH, RESP)
package dict_codec_pkg;
  typedef enum logic [1:0] {
    CMD_NOP    = 2'b00,
    CMD_COMP   = 2'b01,
    CMD_DECOMP = 2'b10,
    CMD_CLEAR  = 2'b11
  } cmd_e;

  typedef enum logic [1:0] {
    RSP_NONE   = 2'b00,
    RSP_COMP   = 2'b01,
    RSP_DECOMP = 2'b10,
    RSP_ERR    = 2'b11
  } rsp_e;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    SEARCH = 2'b01,
    RESP   = 2'b10
  } state_e;
endpackage

// File: rtl/dict_codec_engine_if.sv
// dict_codec_engine_if: request/response handshake bundle.
//   Request : req_valid/req_ready, req_cmd, req_data, req_code
//   Response: rsp_valid/rsp_ready, rsp_status, rsp_code, rsp_data, rsp_hit
//   master = requester side, slave = engine side.
interface dict_codec_engine_if #(
  parameter int DATA_W = 80,
  parameter int DEPTH  = 256
);
  import dict_codec_pkg::*;
  localparam int IDX_W = $clog2(DEPTH);

  logic              req_valid;
  logic              req_ready;
  cmd_e              req_cmd;
  logic [DATA_W-1:0] req_data;
  logic [IDX_W-1:0]  req_code;
  logic              rsp_valid;
  logic              rsp_ready;
  rsp_e              rsp_status;
  logic [IDX_W-1:0]  rsp_code;
  logic [DATA_W-1:0] rsp_data;
  logic              rsp_hit;

  modport master (
    output req_valid, req_cmd, req_data, req_code, rsp_ready,
    input  req_ready, rsp_valid, rsp_status, rsp_code, rsp_data, rsp_hit
  );
  modport slave (
    input  req_valid, req_cmd, req_data, req_code, rsp_ready,
    output req_ready, rsp_valid, rsp_status, rsp_code, rsp_data, rsp_hit
  );
endinterface

// File: rtl/dict_codec_engine_store.sv
// dict_store: DEPTH x DATA_W register array holding dictionary words.
//   clk          : clock
//   we/waddr/wdata : single write port, written on the clock edge
//   raddr/rdata  : single combinational read port
// Contents are not reset; validity is tracked by the engine's count.
module dict_store #(
  parameter  int DATA_W = 80,
  parameter  int DEPTH  = 256,
  localparam int IDX_W  = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [IDX_W-1:0]  waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [IDX_W-1:0]  raddr,
  output logic [DATA_W-1:0] rdata
);
  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk)
    if (we) mem[waddr] <= wdata;

  assign rdata = mem[raddr];
endmodule

// File: rtl/dict_codec_engine.sv
// dict_codec_engine: dictionary compressor/decompressor.
//   clk, reset (async, active-high)
//   bus        : dict_codec_engine_if.slave request/response handshake
//   dict_count : number of valid entries (0..DEPTH)
//   dict_full  : dict_count == DEPTH
// COMP scans entries 0..count-1, one per cycle; the lowest match wins,
// otherwise the word is appended at index count.
// Optional macro DICT_REPLACE_EN: a COMP miss on a full dictionary overwrites
// the entry at a round-robin victim pointer instead of returning ERR.
module dict_codec_engine
  import dict_codec_pkg::*;
#(
  parameter int DATA_W = 80,
  parameter int DEPTH  = 256
) (
  input  logic                   clk,
  input  logic                   reset,
  dict_codec_engine_if.slave     bus,
  output logic [$clog2(DEPTH):0] dict_count,
  output logic                   dict_full
);
  localparam int             IDX_W   = $clog2(DEPTH);
  localparam logic [IDX_W:0] DEPTH_C = (IDX_W+1)'(DEPTH);

  typedef struct packed {
    rsp_e              status;
    logic [IDX_W-1:0]  code;
    logic [DATA_W-1:0] data;
    logic              hit;
  } rsp_t;

  state_e            state, state_nxt;
  logic [IDX_W:0]    count, count_d, ptr, ptr_d;
  logic [DATA_W-1:0] key, rd_data;
  logic [IDX_W-1:0]  rd_addr, waddr;
  rsp_t              rsp_q, rsp_d;
  logic              accept, hit, full, we;
`ifdef DICT_REPLACE_EN
  logic [IDX_W-1:0]  victim, victim_d;
`endif

  assign accept = bus.req_valid && bus.req_ready;
  assign full   = (count == DEPTH_C);
  // Read port serves DECOMP at accept time, otherwise the search pointer.
  assign rd_addr = (state == IDLE) ? bus.req_code : ptr[IDX_W-1:0];
  assign hit     = (ptr < count) && (rd_data == key);

  dict_store #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_store (
    .clk(clk), .we(we), .waddr(waddr), .wdata(key),
    .raddr(rd_addr), .rdata(rd_data)
  );

  always_ff @(posedge clk or posedge reset)
    if (reset) state <= IDLE;
    else       state <= state_nxt;

  always_comb begin
    state_nxt = state;
    rsp_d     = rsp_q;
    count_d   = count;
    ptr_d     = ptr;
    we        = 1'b0;
    waddr     = count[IDX_W-1:0];
`ifdef DICT_REPLACE_EN
    victim_d  = victim;
`endif
    case (state)
      IDLE: if (accept) begin
        rsp_d     = '0;
        state_nxt = RESP;
        case (bus.req_cmd)
          CMD_COMP: begin
            state_nxt = SEARCH;
            ptr_d     = '0;
          end
          CMD_DECOMP:
            if ({1'b0, bus.req_code} < count) begin
              rsp_d.status = RSP_DECOMP;
              rsp_d.data   = rd_data;
            end else
              rsp_d.status = RSP_ERR;
          CMD_CLEAR: begin
            count_d = '0;
`ifdef DICT_REPLACE_EN
            victim_d = '0;
`endif
          end
          default: ;
        endcase
      end
      SEARCH:
        if (hit) begin
          rsp_d.status = RSP_COMP;
          rsp_d.code   = ptr[IDX_W-1:0];
          rsp_d.hit    = 1'b1;
          state_nxt    = RESP;
        end else if (ptr == count) begin
          state_nxt = RESP;
          if (!full) begin
            we           = 1'b1;
            rsp_d.status = RSP_COMP;
            rsp_d.code   = count[IDX_W-1:0];
            count_d      = count + (IDX_W+1)'(1);
          end
`ifdef DICT_REPLACE_EN
          else begin
            we           = 1'b1;
            waddr        = victim;
            rsp_d.status = RSP_COMP;
            rsp_d.code   = victim;
            victim_d     = (victim == IDX_W'(DEPTH-1)) ? '0 : victim + IDX_W'(1);
          end
`else
          else
            rsp_d.status = RSP_ERR;
`endif
        end else
          ptr_d = ptr + (IDX_W+1)'(1);
      RESP:
        if (bus.rsp_ready) begin
          state_nxt = IDLE;
          rsp_d     = '0;
        end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      count <= '0;
      ptr   <= '0;
      key   <= '0;
      rsp_q <= '0;
`ifdef DICT_REPLACE_EN
      victim <= '0;
`endif
    end else begin
      count <= count_d;
      ptr   <= ptr_d;
      rsp_q <= rsp_d;
      if (accept) key <= bus.req_data;
`ifdef DICT_REPLACE_EN
      victim <= victim_d;
`endif
    end

  assign bus.req_ready  = (state == IDLE) && !reset;
  assign bus.rsp_valid  = (state == RESP);
  assign bus.rsp_status = rsp_q.status;
  assign bus.rsp_code   = rsp_q.code;
  assign bus.rsp_data   = rsp_q.data;
  assign bus.rsp_hit    = rsp_q.hit;
  assign dict_count     = count;
  assign dict_full      = full;
endmodule
